// File: rtl/sdm_adc_data_aurora_send.sv
// Streams 512-bit SDM/ADC sample frames to an Aurora AXI-Stream TX port as nine
// 63-bit beats, tagging the first beat with bit 63 and appending a frame sequence number.
module sdm_adc_data_aurora_send #(
    parameter int SEQ_WIDTH = 16
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic [511:0] DIN,
    input  logic         DIN_VALID,
    output logic         DIN_READY,
    input  logic         CHANNEL_UP,
    output logic [63:0]  S_AXI_TX_TDATA,
    output logic         S_AXI_TX_TVALID,
    input  logic         S_AXI_TX_TREADY,
    output logic [15:0]  DROP_CNT,
    output logic         BUSY
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_r, state_n;
    logic [3:0]             k_r, k_n;
    logic [63:0]            tdata_r, tdata_n;
    logic [503:0]           shift_r, shift_n;
    logic [SEQ_WIDTH-1:0]   seq_r, seq_n;
    logic [15:0]            drop_r, drop_n;

    logic                   last_hs_s;
    logic                   ready_s;
    logic                   accept_s;
    logic [SEQ_WIDTH-1:0]   seq_inc_s;
    logic [SEQ_WIDTH-1:0]   accept_seq_s;
    logic [566:0]           payload_s;

    // Handshake qualification and payload assembly for a frame accepted this cycle
    always_comb begin
        last_hs_s    = (state_r == SEND) && (k_r == 4'd8) && S_AXI_TX_TREADY;
        ready_s      = RESET_N && CHANNEL_UP && ((state_r == IDLE) || last_hs_s);
        accept_s     = ready_s && DIN_VALID;
        seq_inc_s    = seq_r + SEQ_WIDTH'(1'b1);
        // A frame accepted on the final beat already carries the incremented number
        accept_seq_s = (state_r == SEND) ? seq_inc_s : seq_r;
        payload_s    = {55'(accept_seq_s), DIN};
    end

    // Next-state and next-beat logic
    always_comb begin
        state_n = state_r;
        k_n     = k_r;
        tdata_n = tdata_r;
        shift_n = shift_r;
        seq_n   = seq_r;
        drop_n  = drop_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = SEND;
                    k_n     = 4'd0;
                    tdata_n = {1'b1, payload_s[62:0]};
                    shift_n = payload_s[566:63];
                end else begin
                    tdata_n = 64'd0;
                end
            end
            SEND: begin
                if (!CHANNEL_UP) begin
                    // Link loss aborts the frame; sequence number is kept for the retry
                    state_n = IDLE;
                    k_n     = 4'd0;
                    tdata_n = 64'd0;
                    shift_n = 504'd0;
                    if (drop_r != 16'hFFFF) begin
                        drop_n = drop_r + 16'd1;
                    end else begin
                        drop_n = drop_r;
                    end
                end else if (S_AXI_TX_TREADY) begin
                    if (k_r == 4'd8) begin
                        seq_n = seq_inc_s;
                        if (accept_s) begin
                            k_n     = 4'd0;
                            tdata_n = {1'b1, payload_s[62:0]};
                            shift_n = payload_s[566:63];
                        end else begin
                            state_n = IDLE;
                            k_n     = 4'd0;
                            tdata_n = 64'd0;
                            shift_n = 504'd0;
                        end
                    end else begin
                        k_n     = k_r + 4'd1;
                        tdata_n = {1'b0, shift_r[62:0]};
                        shift_n = {63'd0, shift_r[503:63]};
                    end
                end else begin
                    tdata_n = tdata_r;
                end
            end
            default: begin
                state_n = IDLE;
                k_n     = 4'd0;
                tdata_n = 64'd0;
                shift_n = 504'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r <= IDLE;
            k_r     <= 4'd0;
            tdata_r <= 64'd0;
            shift_r <= 504'd0;
            seq_r   <= '0;
            drop_r  <= 16'd0;
        end else begin
            state_r <= state_n;
            k_r     <= k_n;
            tdata_r <= tdata_n;
            shift_r <= shift_n;
            seq_r   <= seq_n;
            drop_r  <= drop_n;
        end
    end

    assign DIN_READY       = ready_s;
    assign S_AXI_TX_TDATA  = tdata_r;
    assign S_AXI_TX_TVALID = (state_r == SEND);
    assign BUSY            = (state_r == SEND);
    assign DROP_CNT        = drop_r;

endmodule

// File: tb/tb_sdm_adc_data_aurora_send.sv
// Bench for sdm_adc_data_aurora_send: a frame-level reference model checked every cycle
// against two instances (16-bit and 2-bit sequence), plus directed literal expectations.
module tb_sdm_adc_data_aurora_send;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] din;
    logic         din_valid;
    logic         chup;
    logic         tready;

    logic         ready_a, tvalid_a, busy_a, ready_b, tvalid_b, busy_b;
    logic [63:0]  tdata_a, tdata_b;
    logic [15:0]  drop_a, drop_b;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [511:0] D1 = {8{64'h0123456789abcdef}};

    always #5 clk = ~clk;

    sdm_adc_data_aurora_send #(.SEQ_WIDTH(16)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(ready_a),
        .CHANNEL_UP(chup), .S_AXI_TX_TDATA(tdata_a), .S_AXI_TX_TVALID(tvalid_a),
        .S_AXI_TX_TREADY(tready), .DROP_CNT(drop_a), .BUSY(busy_a)
    );

    sdm_adc_data_aurora_send #(.SEQ_WIDTH(2)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(ready_b),
        .CHANNEL_UP(chup), .S_AXI_TX_TDATA(tdata_b), .S_AXI_TX_TVALID(tvalid_b),
        .S_AXI_TX_TREADY(tready), .DROP_CNT(drop_b), .BUSY(busy_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: frame payload kept whole, beat k sliced out on demand
    bit           m_busy = 1'b0;
    int           m_k    = 0;
    int           m_seq  = 0;
    int           m_drop = 0;
    logic [566:0] m_pay_a, m_pay_b;

    function automatic logic [566:0] mk_pay(input logic [511:0] d, input int seq, input int w);
        logic [54:0] s;
        s = 55'(seq) & ((55'd1 << w) - 55'd1);
        return {s, d};
    endfunction

    function automatic logic [63:0] beat(input logic [566:0] pay, input int k);
        logic [63:0] r;
        r[62:0] = pay[63*k +: 63];
        r[63]   = (k == 0);
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit rdy;
        int seq_nx;
        if (!rst_n) begin
            m_busy <= 1'b0; m_k <= 0; m_seq <= 0; m_drop <= 0;
        end else begin
            rdy = chup && (!m_busy || (m_k == 8 && tready));
            if (m_busy && !chup) begin
                m_busy <= 1'b0; m_k <= 0;
                if (m_drop < 65535) m_drop <= m_drop + 1;
            end else if (m_busy && tready) begin
                if (m_k == 8) begin
                    seq_nx = m_seq + 1;
                    m_seq <= seq_nx;
                    m_k   <= 0;
                    if (rdy && din_valid) begin
                        m_pay_a <= mk_pay(din, seq_nx, 16);
                        m_pay_b <= mk_pay(din, seq_nx, 2);
                    end else begin
                        m_busy <= 1'b0;
                    end
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (!m_busy && rdy && din_valid) begin
                m_pay_a <= mk_pay(din, m_seq, 16);
                m_pay_b <= mk_pay(din, m_seq, 2);
                m_busy  <= 1'b1;
                m_k     <= 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_ready;
        #3;
        exp_ready = rst_n && chup && (!m_busy || (m_k == 8 && tready));
        chk("ready_a",  ready_a,  exp_ready);
        chk("ready_b",  ready_b,  exp_ready);
        chk("tvalid_a", tvalid_a, m_busy);
        chk("tvalid_b", tvalid_b, m_busy);
        chk("busy_a",   busy_a,   m_busy);
        chk("busy_b",   busy_b,   m_busy);
        chk("tdata_a",  tdata_a,  m_busy ? beat(m_pay_a, m_k) : 64'd0);
        chk("tdata_b",  tdata_b,  m_busy ? beat(m_pay_b, m_k) : 64'd0);
        chk("drop_a",   drop_a,   64'(m_drop));
        chk("drop_b",   drop_b,   64'(m_drop));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; din_valid = 1'b0; chup = 1'b1; tready = 1'b1;
        for (int j = 0; j < n; j++) begin
            tick();
            #4;
            chk("rst_tvalid", tvalid_a, 64'd0);
            chk("rst_tdata",  tdata_a,  64'd0);
            chk("rst_ready",  ready_a,  64'd0);
            chk("rst_drop",   drop_a,   64'd0);
        end
        tick();
        rst_n = 1'b1;
    endtask

    // Sends n frames of D1 back to back; seq0 is the sequence number of the first one
    task automatic run_frames(input int n, input int seq0);
        din = D1; din_valid = 1'b1; tready = 1'b1; chup = 1'b1;
        tick();
        for (int i = 0; i < 9 * n; i++) begin
            if (i == 9 * n - 1) din_valid = 1'b0;
            #4;
            chk("bb_tvalid", tvalid_a, 64'd1);
            chk("bb_bit63",  tdata_a[63], (i % 9 == 0) ? 64'd1 : 64'd0);
            if (i % 9 == 0) chk("beat0_lit", tdata_a, 64'h8123456789abcdef);
            if (i % 9 == 8) begin
                chk("beat8_lit_a", tdata_a, 64'h1 | (64'(seq0 + i / 9) << 8));
                chk("beat8_lit_b", tdata_b, 64'h1 | (64'((seq0 + i / 9) % 4) << 8));
            end
            tick();
        end
        #4;
        chk("end_tvalid", tvalid_a, 64'd0);
        chk("end_tdata",  tdata_a,  64'd0);
        tick();
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; din = '0; din_valid = 1'b0; chup = 1'b1; tready = 1'b1;

        // Single frame, then back-to-back and sequence wrap
        do_reset(2);
        run_frames(1, 0);
        do_reset(2);
        run_frames(3, 0);
        do_reset(2);
        run_frames(5, 0);

        // Backpressure with alternating TREADY
        do_reset(2);
        for (int i = 0; i < 16; i++) din[32*i +: 32] = 32'h9e3779b9 * 32'(i + 1);
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tready = (c % 2 == 0);
            #4;
            if (tvalid_a) cnt++;
            tick();
        end
        chk("bp_cycles", 64'(cnt), 64'd17);
        tready = 1'b1;

        // Link drop mid-frame, then on the final-beat handshake
        do_reset(2);
        din = D1; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (4) tick();
        chup = 1'b0;
        #4; chk("drop_ready", ready_a, 64'd0);
        tick();
        #4; chk("drop_tvalid", tvalid_a, 64'd0); chk("drop_cnt1", drop_a, 64'd1);
        din_valid = 1'b1;
        repeat (3) begin
            tick();
            #4; chk("down_ready", ready_a, 64'd0); chk("down_tvalid", tvalid_a, 64'd0);
        end
        tick();
        run_frames(1, 0);
        din_valid = 1'b1;
        tick();
        repeat (8) tick();
        chup = 1'b0;
        #4; chk("last_abort_ready", ready_a, 64'd0);
        tick();
        #4; chk("last_abort_tvalid", tvalid_a, 64'd0); chk("drop_cnt2", drop_a, 64'd2);
        tick();
        run_frames(1, 1);

        // Reset in the middle of a frame
        do_reset(2);
        run_frames(1, 0);
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        repeat (2) begin
            tick();
            #4;
            chk("mid_rst_tvalid", tvalid_a, 64'd0);
            chk("mid_rst_tdata",  tdata_a,  64'd0);
            chk("mid_rst_ready",  ready_a,  64'd0);
        end
        tick();
        rst_n = 1'b1;
        run_frames(1, 0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
